// File: rtl/multi_rate_meter.sv
// Multi-channel event-rate meter.
// Each channel counts synchronised rising edges on an asynchronous input line over a
// programmable window of clk cycles. Once per window it publishes the rate, the running
// min/max, a saturation flag and a limit alarm.
//
// Ports:
//   clk        - clock; all logic runs in this domain
//   reset      - asynchronous reset, active high
//   period     - window length in clk cycles (0 is treated as 1), sampled at window start
//   sig        - asynchronous measured lines, one per channel
//   lo_limit   - lower alarm limit shared by all channels
//   hi_limit   - upper alarm limit shared by all channels
//   clear      - synchronous restart of the window and of min/max tracking
//   rate       - edge count of the last completed window, channel i at [i*WIDTH +: WIDTH]
//   rate_valid - one-cycle strobe when rate/min/max/ovf/alarm update
//   rate_min   - per-channel minimum rate since reset/clear
//   rate_max   - per-channel maximum rate since reset/clear
//   ovf        - per-channel: last completed window saturated
//   alarm      - per-channel: last rate < lo_limit or > hi_limit
module multi_rate_meter #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned PWIDTH      = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PWIDTH-1:0]         period,
  input  logic [CHANNELS-1:0]       sig,
  input  logic [WIDTH-1:0]          lo_limit,
  input  logic [WIDTH-1:0]          hi_limit,
  input  logic                      clear,
  output logic [CHANNELS*WIDTH-1:0] rate,
  output logic                      rate_valid,
  output logic [CHANNELS*WIDTH-1:0] rate_min,
  output logic [CHANNELS*WIDTH-1:0] rate_max,
  output logic [CHANNELS-1:0]       ovf,
  output logic [CHANNELS-1:0]       alarm
);

  localparam logic [WIDTH-1:0] CntMax = '1;

  logic [CHANNELS-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CHANNELS-1:0]                  prev_q, prev_d, edge_det;
  logic [PWIDTH-1:0]                    win_cnt_q, win_cnt_d, len_q, len_d, cur_len;
  logic                                 end_cycle;
  logic [CHANNELS-1:0][WIDTH-1:0]       count_q, count_d, count_inc;
  logic [CHANNELS-1:0]                  sat_q, sat_d, sat_inc;
  logic [CHANNELS-1:0][WIDTH-1:0]       rate_q, rate_d, min_q, min_d, max_q, max_d;
  logic [CHANNELS-1:0]                  ovf_q, ovf_d, alarm_q, alarm_d;
  logic                                 valid_q, valid_d;
  logic                                 first_q, first_d;

  // Front end: synchronisers, edge detect, saturating per-window increment.
  always_comb begin
    // In the first cycle of a window the length comes straight from period, so a
    // one-cycle window is already its own end cycle.
    cur_len = len_q;
    if (win_cnt_q == '0) begin
      cur_len = (period == '0) ? PWIDTH'(1) : period;
    end
    end_cycle = (win_cnt_q == cur_len - PWIDTH'(1));

    for (int c = 0; c < int'(CHANNELS); c++) begin
      sync_d[c]    = {sync_q[c][SYNC_STAGES-2:0], sig[c]};
      prev_d[c]    = sync_q[c][SYNC_STAGES-1];
      edge_det[c]  = sync_q[c][SYNC_STAGES-1] & ~prev_q[c];
      count_inc[c] = count_q[c];
      sat_inc[c]   = sat_q[c];
      if (edge_det[c]) begin
        if (count_q[c] == CntMax) begin
          sat_inc[c] = 1'b1;
        end else begin
          count_inc[c] = count_q[c] + WIDTH'(1);
        end
      end
    end
  end

  // Window sequencing and publication.
  always_comb begin
    win_cnt_d = win_cnt_q;
    len_d     = len_q;
    count_d   = count_q;
    sat_d     = sat_q;
    rate_d    = rate_q;
    min_d     = min_q;
    max_d     = max_q;
    ovf_d     = ovf_q;
    alarm_d   = alarm_q;
    valid_d   = 1'b0;
    first_d   = first_q;

    if (clear) begin
      // Abort the window; published values hold, edges this cycle are dropped.
      win_cnt_d = '0;
      count_d   = '0;
      sat_d     = '0;
      first_d   = 1'b1;
    end else begin
      if (win_cnt_q == '0) begin
        len_d = cur_len;
      end
      if (end_cycle) begin
        win_cnt_d = '0;
        valid_d   = 1'b1;
        first_d   = 1'b0;
        count_d   = '0;
        sat_d     = '0;
        rate_d    = count_inc;
        ovf_d     = sat_inc;
        for (int c = 0; c < int'(CHANNELS); c++) begin
          alarm_d[c] = (count_inc[c] < lo_limit) | (count_inc[c] > hi_limit);
          if (first_q) begin
            min_d[c] = count_inc[c];
            max_d[c] = count_inc[c];
          end else begin
            if (count_inc[c] < min_q[c]) min_d[c] = count_inc[c];
            if (count_inc[c] > max_q[c]) max_d[c] = count_inc[c];
          end
        end
      end else begin
        win_cnt_d = win_cnt_q + PWIDTH'(1);
        count_d   = count_inc;
        sat_d     = sat_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      prev_q    <= '0;
      win_cnt_q <= '0;
      len_q     <= '0;
      count_q   <= '0;
      sat_q     <= '0;
      rate_q    <= '0;
      min_q     <= '0;
      max_q     <= '0;
      ovf_q     <= '0;
      alarm_q   <= '0;
      valid_q   <= 1'b0;
      first_q   <= 1'b1;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      win_cnt_q <= win_cnt_d;
      len_q     <= len_d;
      count_q   <= count_d;
      sat_q     <= sat_d;
      rate_q    <= rate_d;
      min_q     <= min_d;
      max_q     <= max_d;
      ovf_q     <= ovf_d;
      alarm_q   <= alarm_d;
      valid_q   <= valid_d;
      first_q   <= first_d;
    end
  end

  assign rate       = rate_q;
  assign rate_valid = valid_q;
  assign rate_min   = min_q;
  assign rate_max   = max_q;
  assign ovf        = ovf_q;
  assign alarm      = alarm_q;

endmodule
